spectrum_bar_ctrl: RTL and testbench
====================================

Name: spectrum_bar_ctrl

Overview:
- Frame-synchronous display controller for the spectrum analyzer video path.
- Sits between the FFT magnitude producer and the HDMI/VGA timing output, replacing the fixed-colour pattern stage.
- Holds per-bar magnitudes in a ping-pong buffer and swaps banks only at frame start, so a frame never tears.
- Sequences the column/bar counters per line and emits delayed sync plus bar/background RGB.

Parameters:
COLOR_DEPTH, 8, bits per colour channel
X_BITS, 13, width of act_x
Y_BITS, 13, width of act_y
H_ACT, 1280, active pixels per line
V_ACT, 720, active lines per frame
NUM_BARS, 64, number of spectrum bars/buffer entries (power of 2)
BAR_W, 20, pixels per bar slot including gap (>= GAP+1)
GAP, 2, background pixels at right end of each slot
MAG_BITS, 10, magnitude width
BAR_COLOR, 24'h05_34_10, bar RGB {r,g,b}
BG_COLOR, 24'h00_00_00, background RGB

Ports:
pix_clk  in  1  pixel clock; sole clock
rstn  in  1  asynchronous active-low reset
act_x  in  X_BITS  active-area x (informational; counters are internal)
act_y  in  Y_BITS  active-area y, 0 = top line, valid with de_in
vs_in  in  1  vertical sync from timing generator (active high)
hs_in  in  1  horizontal sync
de_in  in  1  data enable
mag_wr_en  in  1  magnitude write strobe
mag_wr_addr  in  log2(NUM_BARS)  bar index
mag_wr_data  in  MAG_BITS  magnitude
mag_frame_done  in  1  one-cycle pulse: write bank complete
vs_out  out  1  vs_in delayed 2 cycles
hs_out  out  1  hs_in delayed 2 cycles
de_out  out  1  de_in delayed 2 cycles
r_out, g_out, b_out  out  COLOR_DEPTH each  pixel colour
disp_bank  out  1  bank currently displayed
swap_pulse  out  1  one-cycle pulse on bank swap
drop_cnt  out  8  saturating count of overwritten pending frames

Behaviour:
Reset (async, rstn=0):
- All outputs 0; disp_bank=0, pending=0, disp_valid=0, drop_cnt=0.
- Internal counters 0; buffer RAM contents not reset.
- Reset mid-frame: outputs go to 0 immediately; on release, display resumes black until a swap.

Write side:
- Writes target bank ~disp_bank. Writes with addr >= NUM_BARS are impossible by width.
- Writes are accepted in every state, including while pending; latest write wins.

Swap FSM, states IDLE and PENDING:
- IDLE --mag_frame_done--> PENDING.
- PENDING --mag_frame_done--> PENDING, drop_cnt+1 (saturates at 255).
- A vs_in rising edge (vs_in=1, previous vs_in=0) while PENDING: disp_bank toggles, disp_valid=1, swap_pulse=1 for one cycle, state -> IDLE.
- mag_frame_done coincident with a vs rising edge in IDLE: swap in that same cycle; no drop.
- Coincident with a vs rising edge in PENDING: swap, no drop increment.

Column sequencing:
- While de_in=0: pix_cnt=0, col=0.
- During de_in=1: pix_cnt increments each cycle. At pix_cnt=BAR_W-1 it wraps to 0 and col increments, saturating at NUM_BARS.
- Pixel is bar-eligible if col<NUM_BARS and pix_cnt<BAR_W-GAP.

Height rule:
- h = min(mag[disp_bank][col], V_ACT).
- Pixel is bar if disp_valid and eligible and h!=0 and act_y >= V_ACT-h.
- Comparison is unsigned at width max(Y_BITS,MAG_BITS)+1.

Pipeline and output:
- Stage 1: synchronous RAM read at col, register eligible/act_y/syncs.
- Stage 2: compare and colour select.
- Total latency 2 cycles for vs/hs/de/rgb, all aligned.
- rgb = BAR_COLOR if bar; BG_COLOR if de but not bar; 0 when delayed de=0.
- A swap during active video is impossible by construction: the swap occurs only on the vs edge.
- The read bank latches at the swap cycle; a swap pixel in flight uses the new bank.

Test Plan:
- Reset: rstn=0 mid-line with de_in=1 -> all outputs 0 at once. After release with no frame_done, a full frame is rgb=BG_COLOR(0) with de_out=de_in delayed 2.
- Single frame: write mag[0..63]=i*10, pulse frame_done, then vs edge -> swap_pulse=1 for one cycle, disp_bank=1. At line act_y=719, bar0 pixels 0..17 are black (h=0) and bar1 pixels 20..37 are 05_34_10. Gap pixels 38,39 are black; x>=1280 never reached.
- Height boundary: mag[5]=720 -> bar on act_y=0 for x 100..117. mag[6]=1023 clamps to 720, same result. mag[7]=1 -> only act_y=719 is lit.
- Overrun: three frame_done pulses before a vs edge -> drop_cnt=2, exactly one swap. 300 overruns -> drop_cnt=255.
- Coincidence: frame_done on the same cycle as a vs rising edge -> swap that cycle, drop_cnt unchanged. Writes after it land in the new write bank and are not visible until the next swap.
- Latency: de_in/hs_in/vs_in toggles -> outputs follow exactly 2 pix_clk later. Colour edges align with de_out rising.

Source files
------------

// File: rtl/spectrum_bar_ctrl.sv
// Spectrum bar display controller: ping-pong magnitude buffer swapped on
// vsync, per-line bar sequencing and a 2-cycle aligned sync/RGB pipeline.
module spectrum_bar_ctrl #(
  parameter int COLOR_DEPTH = 8,
  parameter int X_BITS      = 13,
  parameter int Y_BITS      = 13,
  parameter int H_ACT       = 1280,
  parameter int V_ACT       = 720,
  parameter int NUM_BARS    = 64,
  parameter int BAR_W       = 20,
  parameter int GAP         = 2,
  parameter int MAG_BITS    = 10,
  parameter logic [3*COLOR_DEPTH-1:0] BAR_COLOR = 24'h05_34_10,
  parameter logic [3*COLOR_DEPTH-1:0] BG_COLOR  = 24'h00_00_00
) (
  input  logic                        pix_clk,
  input  logic                        rstn,
  input  logic [X_BITS-1:0]           act_x,
  input  logic [Y_BITS-1:0]           act_y,
  input  logic                        vs_in,
  input  logic                        hs_in,
  input  logic                        de_in,
  input  logic                        mag_wr_en,
  input  logic [$clog2(NUM_BARS)-1:0] mag_wr_addr,
  input  logic [MAG_BITS-1:0]         mag_wr_data,
  input  logic                        mag_frame_done,
  output logic                        vs_out,
  output logic                        hs_out,
  output logic                        de_out,
  output logic [COLOR_DEPTH-1:0]      r_out,
  output logic [COLOR_DEPTH-1:0]      g_out,
  output logic [COLOR_DEPTH-1:0]      b_out,
  output logic                        disp_bank,
  output logic                        swap_pulse,
  output logic [7:0]                  drop_cnt
);

  localparam int AW  = $clog2(NUM_BARS);
  localparam int CW  = AW + 1;
  localparam int PW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int HW  = ((Y_BITS > MAG_BITS) ? Y_BITS : MAG_BITS) + 1;
  localparam int CD3 = 3 * COLOR_DEPTH;
  localparam logic [HW-1:0] VACT = HW'(V_ACT);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_swap;
  logic   w_drop_inc;
  logic   w_vs_rise;
  logic   w_bank_nxt;
  logic   r_vs_prev;
  logic   r_disp_bank;
  logic   r_disp_valid;
  logic   r_swap;
  logic [7:0] r_drop;

  logic [PW-1:0] r_pix;
  logic [CW-1:0] r_col;
  logic          w_elig;

  logic [MAG_BITS-1:0] r_mem [2*NUM_BARS];
  logic [MAG_BITS-1:0] r_mag1;
  logic [Y_BITS-1:0]   r_y1;
  logic r_vs1, r_hs1, r_de1, r_elig1, r_valid1;

  logic [HW-1:0] w_mag_ext;
  logic [HW-1:0] w_h;
  logic [HW-1:0] w_thr;
  logic          w_bar;
  logic [CD3-1:0] r_rgb;
  logic r_vs2, r_hs2, r_de2;

  logic w_unused;
  assign w_unused = ^{act_x, X_BITS'(H_ACT)};

  assign w_vs_rise  = vs_in & ~r_vs_prev;
  assign w_bank_nxt = r_disp_bank ^ w_swap;

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    w_drop_inc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mag_frame_done) begin
          if (w_vs_rise) w_swap = 1'b1;
          else           w_state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (w_vs_rise) begin
          w_swap      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (mag_frame_done) begin
          w_drop_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_vs_prev    <= 1'b0;
      r_disp_bank  <= 1'b0;
      r_disp_valid <= 1'b0;
      r_swap       <= 1'b0;
      r_drop       <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_vs_prev <= vs_in;
      r_swap    <= w_swap;
      if (w_swap) begin
        r_disp_bank  <= ~r_disp_bank;
        r_disp_valid <= 1'b1;
      end
      if (w_drop_inc && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
    end
  end

  // Column counter saturates so pixels past the last slot stay background
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_pix <= '0;
      r_col <= '0;
    end else if (!de_in) begin
      r_pix <= '0;
      r_col <= '0;
    end else if (r_pix == PW'(BAR_W - 1)) begin
      r_pix <= '0;
      if (r_col != CW'(NUM_BARS))
        r_col <= r_col + 1'b1;
    end else begin
      r_pix <= r_pix + 1'b1;
    end
  end

  assign w_elig = (r_col < CW'(NUM_BARS)) &&
                  (r_pix < PW'(BAR_W - GAP));

  // Read uses the post-swap bank so a pixel in the swap cycle sees new data
  always_ff @(posedge pix_clk) begin
    if (mag_wr_en)
      r_mem[{~r_disp_bank, mag_wr_addr}] <= mag_wr_data;
    r_mag1 <= r_mem[{w_bank_nxt, r_col[AW-1:0]}];
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_vs1    <= 1'b0;
      r_hs1    <= 1'b0;
      r_de1    <= 1'b0;
      r_elig1  <= 1'b0;
      r_valid1 <= 1'b0;
      r_y1     <= '0;
    end else begin
      r_vs1    <= vs_in;
      r_hs1    <= hs_in;
      r_de1    <= de_in;
      r_elig1  <= w_elig;
      r_valid1 <= r_disp_valid | w_swap;
      r_y1     <= act_y;
    end
  end

  assign w_mag_ext = HW'(r_mag1);
  assign w_h       = (w_mag_ext > VACT) ? VACT : w_mag_ext;
  assign w_thr     = VACT - w_h;
  assign w_bar     = r_valid1 & r_elig1 & (w_h != '0) &
                     (HW'(r_y1) >= w_thr);

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      r_vs2 <= 1'b0;
      r_hs2 <= 1'b0;
      r_de2 <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_vs2 <= r_vs1;
      r_hs2 <= r_hs1;
      r_de2 <= r_de1;
      if (!r_de1)     r_rgb <= '0;
      else if (w_bar) r_rgb <= BAR_COLOR;
      else            r_rgb <= BG_COLOR;
    end
  end

  assign vs_out     = r_vs2;
  assign hs_out     = r_hs2;
  assign de_out     = r_de2;
  assign {r_out, g_out, b_out} = r_rgb;
  assign disp_bank  = r_disp_bank;
  assign swap_pulse = r_swap;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_spectrum_bar_ctrl.sv
// Bench for spectrum_bar_ctrl on a scaled-down raster; a reference model
// fills a pixel scoreboard that a forked monitor drains on de_out.
module tb_spectrum_bar_ctrl;

  localparam int CD   = 8;
  localparam int XB   = 13;
  localparam int YB   = 13;
  localparam int HACT = 44;
  localparam int VACT = 16;
  localparam int NB   = 8;
  localparam int BW   = 5;
  localparam int GP   = 2;
  localparam int MB   = 10;
  localparam int AW   = 3;
  localparam logic [23:0] BAR = 24'h05_34_10;
  localparam logic [23:0] BG  = 24'h00_00_00;

  logic pix_clk, rstn;
  logic [XB-1:0] act_x;
  logic [YB-1:0] act_y;
  logic vs_in, hs_in, de_in;
  logic mag_wr_en;
  logic [AW-1:0] mag_wr_addr;
  logic [MB-1:0] mag_wr_data;
  logic mag_frame_done;
  logic vs_out, hs_out, de_out;
  logic [CD-1:0] r_out, g_out, b_out;
  logic disp_bank, swap_pulse;
  logic [7:0] drop_cnt;

  spectrum_bar_ctrl #(
    .COLOR_DEPTH(CD), .X_BITS(XB), .Y_BITS(YB),
    .H_ACT(HACT), .V_ACT(VACT), .NUM_BARS(NB),
    .BAR_W(BW), .GAP(GP), .MAG_BITS(MB),
    .BAR_COLOR(BAR), .BG_COLOR(BG)
  ) dut (
    .pix_clk(pix_clk), .rstn(rstn),
    .act_x(act_x), .act_y(act_y),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .mag_wr_en(mag_wr_en), .mag_wr_addr(mag_wr_addr),
    .mag_wr_data(mag_wr_data),
    .mag_frame_done(mag_frame_done),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .disp_bank(disp_bank), .swap_pulse(swap_pulse),
    .drop_cnt(drop_cnt)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [23:0] exp_q [$];

  int m_mem [2][NB];
  int m_bank  = 0;
  bit m_valid = 1'b0;
  bit m_pend  = 1'b0;
  int m_drop  = 0;

  function automatic logic [23:0] exp_rgb(input int x, input int y);
    int c, p, h;
    if (!m_valid) return BG;
    if (x >= NB * BW) return BG;
    c = x / BW;
    p = x % BW;
    if (p >= BW - GP) return BG;
    h = m_mem[m_bank][c];
    if (h > VACT) h = VACT;
    if (h == 0) return BG;
    return (y >= VACT - h) ? BAR : BG;
  endfunction

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic monitor();
    logic [23:0] e;
    forever begin
      @(negedge pix_clk);
      if (mon_en) begin
        total++;
        if (de_out) begin
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pix_unexpected got=%h required=none",
                     {r_out, g_out, b_out});
          end else begin
            e = exp_q.pop_front();
            if ({r_out, g_out, b_out} !== e) begin
              bad++;
              $display("FAIL pix_rgb got=%h required=%h",
                       {r_out, g_out, b_out}, e);
            end
          end
        end else if ({r_out, g_out, b_out} !== 24'h0) begin
          bad++;
          $display("FAIL blank_rgb got=%h required=0",
                   {r_out, g_out, b_out});
        end
      end
    end
  endtask

  task automatic do_line(input int y);
    for (int x = 0; x < HACT; x++) begin
      act_x = XB'(x);
      act_y = YB'(y);
      de_in = 1'b1;
      exp_q.push_back(exp_rgb(x, y));
      tick();
    end
    de_in = 1'b0;
    hs_in = 1'b1;
    tick(); tick();
    hs_in = 1'b0;
    tick(); tick();
  endtask

  task automatic write_mag(input int a, input int d);
    mag_wr_en   = 1'b1;
    mag_wr_addr = AW'(a);
    mag_wr_data = MB'(d);
    m_mem[1 - m_bank][a] = d;
    tick();
    mag_wr_en = 1'b0;
  endtask

  task automatic frame_done();
    mag_frame_done = 1'b1;
    if (m_pend) begin
      if (m_drop < 255) m_drop++;
    end else begin
      m_pend = 1'b1;
    end
    tick();
    mag_frame_done = 1'b0;
    total++;
    if (drop_cnt !== 8'(m_drop)) begin
      bad++;
      $display("FAIL drop_cnt got=%0d required=%0d", drop_cnt, m_drop);
    end
  endtask

  task automatic vs_pulse(input bit with_done);
    bit sw;
    sw = with_done || m_pend;
    vs_in = 1'b1;
    mag_frame_done = with_done;
    if (sw) begin
      m_bank  = 1 - m_bank;
      m_valid = 1'b1;
      m_pend  = 1'b0;
    end
    tick();
    mag_frame_done = 1'b0;
    total += 3;
    if (swap_pulse !== sw) begin
      bad++;
      $display("FAIL swap_pulse got=%b required=%b", swap_pulse, sw);
    end
    if (disp_bank !== 1'(m_bank)) begin
      bad++;
      $display("FAIL disp_bank got=%b required=%0d", disp_bank, m_bank);
    end
    if (drop_cnt !== 8'(m_drop)) begin
      bad++;
      $display("FAIL vs_drop got=%0d required=%0d", drop_cnt, m_drop);
    end
    tick();
    total++;
    if (swap_pulse !== 1'b0) begin
      bad++;
      $display("FAIL swap_width got=%b required=0", swap_pulse);
    end
    tick();
    vs_in = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge pix_clk);
    #1;
    total++;
    if ({vs_out, hs_out, de_out, r_out, g_out, b_out,
         disp_bank, swap_pulse, drop_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%b required=0",
               {vs_out, hs_out, de_out, disp_bank, swap_pulse});
    end
    rstn = 1'b1;
    tick(); tick();
    mon_en = 1'b1;
    do_line(0);
    do_line(VACT - 1);
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < NB; i++) write_mag(i, i * 3);
    frame_done();
    vs_pulse(1'b0);
    do_line(VACT - 1);
    do_line(VACT / 2);
    do_line(0);
  endtask

  task automatic test_height();
    write_mag(0, 15);
    write_mag(1, 0);
    write_mag(2, 8);
    write_mag(3, 2);
    write_mag(4, 0);
    write_mag(5, VACT);
    write_mag(6, 1023);
    write_mag(7, 1);
    frame_done();
    vs_pulse(1'b0);
    do_line(0);
    do_line(1);
    do_line(VACT - 2);
    do_line(VACT - 1);
  endtask

  task automatic test_coincide();
    int d0;
    for (int i = 0; i < NB; i++) write_mag(i, VACT - 2 * i);
    d0 = m_drop;
    vs_pulse(1'b1);
    total++;
    if (drop_cnt !== 8'(d0)) begin
      bad++;
      $display("FAIL coin_drop got=%0d required=%0d", drop_cnt, d0);
    end
    for (int i = 0; i < NB; i++) write_mag(i, VACT);
    do_line(0);
    do_line(VACT - 3);
    frame_done();
    vs_pulse(1'b0);
    do_line(0);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 3; i++) frame_done();
    vs_pulse(1'b0);
    vs_pulse(1'b0);
    do_line(VACT - 4);
    for (int i = 0; i < 301; i++) frame_done();
    total++;
    if (drop_cnt !== 8'd255) begin
      bad++;
      $display("FAIL drop_sat got=%0d required=255", drop_cnt);
    end
    vs_pulse(1'b0);
    do_line(VACT - 1);
  endtask

  task automatic test_latency();
    logic [2:0] h [64];
    mon_en = 1'b0;
    act_y = '0;
    for (int i = 0; i < 64; i++) begin
      tick();
      {vs_in, hs_in, de_in} = 3'($urandom);
      h[i] = {vs_in, hs_in, de_in};
      @(negedge pix_clk);
      if (i >= 2) begin
        total++;
        if ({vs_out, hs_out, de_out} !== h[i-2]) begin
          bad++;
          $display("FAIL sync_lat got=%b required=%b",
                   {vs_out, hs_out, de_out}, h[i-2]);
        end
        if (!de_out && {r_out, g_out, b_out} !== 24'h0) begin
          bad++;
          $display("FAIL lat_rgb got=%h required=0",
                   {r_out, g_out, b_out});
        end
      end
    end
    tick();
    {vs_in, hs_in, de_in} = 3'b000;
    repeat (4) tick();
    mon_en = 1'b1;
  endtask

  task automatic test_midline_reset();
    mon_en = 1'b0;
    for (int x = 0; x < 10; x++) begin
      act_x = XB'(x);
      act_y = YB'(0);
      de_in = 1'b1;
      tick();
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({vs_out, hs_out, de_out, r_out, g_out, b_out,
         disp_bank, swap_pulse, drop_cnt} !== '0) begin
      bad++;
      $display("FAIL midreset got=%b rgb=%h drop=%0d required=0",
               {de_out, disp_bank}, {r_out, g_out, b_out}, drop_cnt);
    end
    de_in = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    m_bank = 0;
    m_valid = 1'b0;
    m_pend = 1'b0;
    m_drop = 0;
    exp_q.delete();
    tick(); tick();
    total++;
    if ({disp_bank, drop_cnt} !== 9'd0) begin
      bad++;
      $display("FAIL post_reset got=%b/%0d required=0/0",
               disp_bank, drop_cnt);
    end
    mon_en = 1'b1;
    do_line(VACT - 1);
    do_line(0);
  endtask

  initial begin
    rstn = 1'b0;
    act_x = '0;
    act_y = '0;
    vs_in = 1'b0;
    hs_in = 1'b0;
    de_in = 1'b0;
    mag_wr_en = 1'b0;
    mag_wr_addr = '0;
    mag_wr_data = '0;
    mag_frame_done = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_frame();
    test_height();
    test_coincide();
    test_overrun();
    test_latency();
    test_midline_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pix_left got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
